sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 3: number of switch inputs; matches the 3-bit PIO input port it feeds.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz); legal range >= 2.
REQ-003 clk  input  1: system clock; all logic on rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 sw_raw  input  WIDTH: raw asynchronous switch levels from pins.
REQ-006 irq_clr  input  1: one-cycle pulse clearing irq_pending.
REQ-007 sw_stable  output  WIDTH: debounced levels; drives the PIO input port.
REQ-008 sw_rise  output  WIDTH: one-cycle pulse per bit on an accepted 0->1 transition.
REQ-009 sw_fall  output  WIDTH: one-cycle pulse per bit on an accepted 1->0 transition.
REQ-010 irq_pending  output  1: sticky flag, set by any accepted transition.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES), reset to 0.
REQ-013 Per bit, per edge: s2 == sw_stable -> counter <= 0, no pulse.
REQ-014 Per bit, per edge: s2 != sw_stable and counter < DEBOUNCE_CYCLES-1 -> counter <= counter+1.
REQ-015 Per bit, per edge: s2 != sw_stable and counter == DEBOUNCE_CYCLES-1 -> sw_stable <= s2, counter <= 0, rise/fall pulse registered.
REQ-016 Latency: a raw change held steady SHALL appear on sw_stable at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge sampling the new level as edge 1.
REQ-017 A raw excursion that returns before acceptance SHALL reset the counter and produce no sw_stable change and no pulse.
REQ-018 sw_rise[i]/sw_fall[i] SHALL be high for exactly the one cycle in which sw_stable[i] first shows the new level; never both high.
REQ-019 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL pulse all of them in the same cycle.
REQ-020 irq_pending SHALL be set on the cycle after any sw_rise or sw_fall bit is high and cleared on the cycle after irq_clr is high.
REQ-021 Simultaneous irq_clr and a new pulse: set wins; irq_pending stays 1.
REQ-022 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-023 All outputs SHALL be registered; no combinational path from sw_raw or irq_clr to any output.

Reset
REQ-024 Reset SHALL force s1, s2, counters, sw_stable, sw_rise, sw_fall and irq_pending to 0 asynchronously.
REQ-025 A bit held 1 through reset release SHALL be reported as a normal 0->1 transition (sw_rise pulse, irq_pending set) after REQ-016 latency.
REQ-026 Reset asserted mid-count SHALL discard the count; no pulse produced for that transition.

Structure
REQ-027 Shared package sw_debounce_pkg SHALL hold default WIDTH, default DEBOUNCE_CYCLES and the counter-width function.
REQ-028 Per-bit logic (synchronizer, counter, stable flop, rise/fall) SHALL be sub-module sw_debounce_bit, instantiated WIDTH times; irq_pending lives in sw_debounce.
REQ-029 Elaboration SHALL fail if DEBOUNCE_CYCLES < 2 or WIDTH < 1.

Verification (bench parameters: WIDTH=3, DEBOUNCE_CYCLES=4)
REQ-030 Reset, sw_raw=3'b000 held 20 cycles -> sw_stable=000, no pulses, irq_pending=0.
REQ-031 sw_raw 000->001 held -> sw_stable=001 at edge 6, sw_rise=001 for that one cycle, irq_pending=1 next cycle.
REQ-032 sw_raw[1] high for 3 cycles then low -> sw_stable unchanged, no pulse, irq_pending unchanged.
REQ-033 sw_stable=111, sw_raw -> 010 held -> sw_fall=101 single cycle, sw_stable=010, sw_rise=000.
REQ-034 irq_pending=1, irq_clr pulsed in same cycle as new sw_rise pulse -> irq_pending stays 1; later lone irq_clr -> 0 next cycle.
REQ-035 reset_n low at counter=2 on bit 0, released with sw_raw[0]=1 -> all outputs 0 during reset; sw_rise[0] 6 edges after release.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared defaults and sizing helper for the switch debouncer.
// Imported by the top and the per-bit debounce slice.
package sw_debounce_pkg;

    localparam int DEFAULT_WIDTH           = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch: two-flop synchronizer, stability counter, accepted level
// and registered rise/fall pulses that coincide with the new stable level.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        s1_d     = sw_raw;
        s2_d     = s1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Any cycle where the synchronized level agrees with the accepted one restarts the count.
        if (s2_q != stable_q) begin
            if (cnt_q >= CNT_MAX) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// WIDTH independent switch debouncers feeding a PIO input port, plus a sticky
// interrupt-pending flag set by any accepted edge and cleared by irq_clr.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             irq_pending
);

    if (WIDTH < 1 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("sw_debounce: WIDTH must be >= 1 and DEBOUNCE_CYCLES >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw   (sw_raw[i]),
            .sw_stable(sw_stable[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i])
        );
    end

    logic irq_pending_q, irq_pending_d;

    always_comb begin
        irq_pending_d = irq_pending_q;
        if (irq_clr) begin
            irq_pending_d = 1'b0;
        end
        // A fresh edge beats a clear arriving in the same cycle.
        if (|sw_rise || |sw_fall) begin
            irq_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_q <= 1'b0;
        end else begin
            irq_pending_q <= irq_pending_d;
        end
    end

    assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with WIDTH=3, DEBOUNCE_CYCLES=4: vector table, reset
// corner sequence, and randomized bouncing against a sliding-window model.
module tb_sw_debounce;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic         irq_clr = 1'b0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         irq_pending;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .irq_clr    (irq_clr),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Reference: a bit flips when the last D synchronized samples all disagree with it.
  // hist[j] is the raw level sampled j+1 edges ago; the synchronizer output is hist[1].
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0, m_flip;
  logic         m_irq = 1'b0;

  initial for (int j = 0; j <= D; j++) hist[j] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_stable = '0;
      m_rise = '0;
      m_fall = '0;
      m_irq = 1'b0;
    end else begin
      m_irq = ((|m_rise) || (|m_fall)) ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
      m_flip = '1;
      for (int j = 1; j <= D; j++) m_flip = m_flip & (hist[j] ^ m_stable);
      m_rise = m_flip & ~m_stable;
      m_fall = m_flip & m_stable;
      m_stable = m_stable ^ m_flip;
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = sw_raw;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_stable", 32'(sw_stable), 32'(m_stable));
      check("mon_rise", 32'(sw_rise), 32'(m_rise));
      check("mon_fall", 32'(sw_fall), 32'(m_fall));
      check("mon_irq", 32'(irq_pending), 32'(m_irq));
    end
  end

  typedef struct packed {
    logic [W-1:0] raw;
    logic         clr;
    logic [7:0]   n;
    logic [W-1:0] e_stable;
    logic [W-1:0] e_rise;
    logic [W-1:0] e_fall;
    logic         e_irq;
  } vec_t;

  vec_t vecs [16];

  task automatic check_outs(input string tag, input logic [W-1:0] es, input logic [W-1:0] er,
                            input logic [W-1:0] ef, input logic ei);
    check({tag, "_stable"}, 32'(sw_stable), 32'(es));
    check({tag, "_rise"}, 32'(sw_rise), 32'(er));
    check({tag, "_fall"}, 32'(sw_fall), 32'(ef));
    check({tag, "_irq"}, 32'(irq_pending), 32'(ei));
  endtask

  // Called at a negedge: apply inputs, let n rising edges pass, then sample.
  task automatic apply(input logic [W-1:0] raw, input logic clr, input int n);
    sw_raw = raw;
    irq_clr = clr;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 8'd20, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{3'b001, 1'b0, 8'd5,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 8'd1,  3'b001, 3'b001, 3'b000, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 8'd1,  3'b001, 3'b000, 3'b000, 1'b1};
    vecs[4]  = '{3'b011, 1'b0, 8'd3,  3'b001, 3'b000, 3'b000, 1'b1};
    vecs[5]  = '{3'b001, 1'b0, 8'd10, 3'b001, 3'b000, 3'b000, 1'b1};
    vecs[6]  = '{3'b001, 1'b1, 8'd1,  3'b001, 3'b000, 3'b000, 1'b0};
    vecs[7]  = '{3'b111, 1'b0, 8'd6,  3'b111, 3'b110, 3'b000, 1'b0};
    vecs[8]  = '{3'b111, 1'b0, 8'd1,  3'b111, 3'b000, 3'b000, 1'b1};
    vecs[9]  = '{3'b010, 1'b0, 8'd6,  3'b010, 3'b000, 3'b101, 1'b1};
    vecs[10] = '{3'b010, 1'b0, 8'd1,  3'b010, 3'b000, 3'b000, 1'b1};
    vecs[11] = '{3'b011, 1'b0, 8'd6,  3'b011, 3'b001, 3'b000, 1'b1};
    vecs[12] = '{3'b011, 1'b1, 8'd1,  3'b011, 3'b000, 3'b000, 1'b1};
    vecs[13] = '{3'b011, 1'b0, 8'd3,  3'b011, 3'b000, 3'b000, 1'b1};
    vecs[14] = '{3'b011, 1'b1, 8'd1,  3'b011, 3'b000, 3'b000, 1'b0};
    vecs[15] = '{3'b011, 1'b0, 8'd2,  3'b011, 3'b000, 3'b000, 1'b0};

    // Clock/reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 3'b000, 3'b000, 3'b000, 1'b0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].raw, vecs[i].clr, int'(vecs[i].n));
      check_outs($sformatf("vec%0d", i), vecs[i].e_stable, vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_irq);
    end

    // Reset mid-count with the switch still high through release.
    apply(3'b010, 1'b0, 8);
    check_outs("pre_fall", 3'b010, 3'b000, 3'b000, 1'b1);
    apply(3'b011, 1'b0, 4);
    check_outs("midcount", 3'b010, 3'b000, 3'b000, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_outs("in_reset", 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("held_reset", 3'b000, 3'b000, 3'b000, 1'b0);
    reset_n = 1'b1;
    apply(3'b011, 1'b0, 5);
    check_outs("rel_e5", 3'b000, 3'b000, 3'b000, 1'b0);
    apply(3'b011, 1'b0, 1);
    check_outs("rel_e6", 3'b011, 3'b011, 3'b000, 1'b0);
    apply(3'b011, 1'b0, 1);
    check_outs("rel_e7", 3'b011, 3'b000, 3'b000, 1'b1);

    // Randomized bouncing; the monitor compares every cycle against the model.
    for (int seg = 0; seg < 400; seg++) begin
      logic [W-1:0] r;
      int hold;
      r = W'($urandom_range(0, (1 << W) - 1));
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        apply(r, ($urandom_range(0, 7) == 0), 1);
      end
      if (seg % 97 == 50) begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
